// File: rtl/pipeline_defs.sv
// Shared decode constants for the 5-stage pipeline hazard logic.
// Holds MIPS opcode/funct codes, the instruction-class enum, Tuse/Tnew
// encodings, Forward_* select codes and small class helper functions.
package pipeline_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_CAL_R, CLS_CAL_I, CLS_LOAD, CLS_STORE, CLS_BEQ,
        CLS_JR, CLS_JAL, CLS_MULT, CLS_DIV, CLS_MF, CLS_MT
    } iclass_e;

    // TUSE_NONE (3) is larger than any Tnew, so an unused operand never stalls
    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;

    localparam logic [2:0] FWD_D_GRF    = 3'd0;
    localparam logic [2:0] FWD_D_PC8_E  = 3'd1;
    localparam logic [2:0] FWD_D_ALU_M  = 3'd2;
    localparam logic [2:0] FWD_D_PC8_M  = 3'd3;
    localparam logic [2:0] FWD_D_GRF_WD = 3'd4;

    localparam logic [1:0] FWD_E_REG    = 2'd0;
    localparam logic [1:0] FWD_E_ALU_M  = 2'd1;
    localparam logic [1:0] FWD_E_PC8_M  = 2'd2;
    localparam logic [1:0] FWD_E_GRF_WD = 2'd3;

    function automatic logic [1:0] tuse_rs(input iclass_e c);
        case (c)
            CLS_BEQ, CLS_JR:                          return TUSE_0;
            CLS_CAL_R, CLS_CAL_I, CLS_LOAD, CLS_STORE,
            CLS_MULT, CLS_DIV, CLS_MT:                return TUSE_1;
            default:                                  return TUSE_NONE;
        endcase
    endfunction

    function automatic logic [1:0] tuse_rt(input iclass_e c);
        case (c)
            CLS_BEQ:                           return TUSE_0;
            CLS_CAL_R, CLS_MULT, CLS_DIV:      return TUSE_1;
            CLS_STORE:                         return TUSE_2;
            default:                           return TUSE_NONE;
        endcase
    endfunction

    // Producer whose result sits on ALUOut once it reaches M
    function automatic logic alu_result(input iclass_e c);
        return (c == CLS_CAL_R) || (c == CLS_CAL_I) || (c == CLS_MF);
    endfunction

    // Instructions that touch HI/LO and must wait for the MDU
    function automatic logic is_mdu(input iclass_e c);
        return (c == CLS_MULT) || (c == CLS_DIV) || (c == CLS_MF) || (c == CLS_MT);
    endfunction

endpackage

// File: rtl/instr_class.sv
// Per-stage instruction decoder.
// Ports: ir_i (instruction word, 0 = nop) -> cls_o (instruction class),
//        waddr_o (GPR written, 0 if none), tnew_o (Tnew as seen in E).
module instr_class
    import pipeline_defs::*;
(
    input  logic [31:0] ir_i,
    output iclass_e     cls_o,
    output logic [4:0]  waddr_o,
    output logic [1:0]  tnew_o
);
    logic [5:0] op, fn;
    logic       unused;

    assign op = ir_i[31:26];
    assign fn = ir_i[5:0];
    assign unused = ^{ir_i[25:21], ir_i[10:6]};

    always_comb begin
        cls_o = CLS_NOP;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADDU, FN_SUBU:   cls_o = CLS_CAL_R;
                    FN_JR:              cls_o = CLS_JR;
                    FN_MFHI, FN_MFLO:   cls_o = CLS_MF;
                    FN_MTHI, FN_MTLO:   cls_o = CLS_MT;
                    FN_MULT, FN_MULTU:  cls_o = CLS_MULT;
                    FN_DIV, FN_DIVU:    cls_o = CLS_DIV;
                    default:            cls_o = CLS_NOP;
                endcase
            end
            OP_ORI, OP_LUI: cls_o = CLS_CAL_I;
            OP_LW:          cls_o = CLS_LOAD;
            OP_SW:          cls_o = CLS_STORE;
            OP_BEQ:         cls_o = CLS_BEQ;
            OP_JAL:         cls_o = CLS_JAL;
            default:        cls_o = CLS_NOP;
        endcase
    end

    always_comb begin
        waddr_o = 5'd0;
        tnew_o  = TNEW_0;
        case (cls_o)
            CLS_CAL_R, CLS_MF: begin waddr_o = ir_i[15:11]; tnew_o = TNEW_1; end
            CLS_CAL_I:         begin waddr_o = ir_i[20:16]; tnew_o = TNEW_1; end
            CLS_LOAD:          begin waddr_o = ir_i[20:16]; tnew_o = TNEW_2; end
            CLS_JAL:           begin waddr_o = 5'd31;       tnew_o = TNEW_0; end
            default:           begin waddr_o = 5'd0;        tnew_o = TNEW_0; end
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline.
// Inputs : clk, reset (sync, active high), IR_D/IR_E/IR_M/IR_W.
// Outputs: PCNen/FD_Nen/DE_clr (stall), Forward_RSD/RTD (D-stage select),
//          Forward_RSE/RTE (E-stage select), Forward_RTM (store data in M),
//          md_start_E (MDU accepts op in E), md_busy (HI/LO pending).
// Optional: HAZARD_PERF_CNT_EN adds stall_cnt / md_stall_cnt cycle counters.
module hazard_ctrl
    import pipeline_defs::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_E,
    input  logic [31:0] IR_M,
    input  logic [31:0] IR_W,
    output logic        PCNen,
    output logic        FD_Nen,
    output logic        DE_clr,
    output logic [2:0]  Forward_RSD,
    output logic [2:0]  Forward_RTD,
    output logic [1:0]  Forward_RSE,
    output logic [1:0]  Forward_RTE,
    output logic        Forward_RTM,
    output logic        md_start_E,
    output logic        md_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] md_stall_cnt
`endif
);
    iclass_e    cls_d, cls_e, cls_m, cls_w;
    logic [4:0] wa_d, wa_e, wa_m, wa_w;
    logic [1:0] tnew_d, tnew_e, tnew_m, tnew_w, tnew_m_eff;
    logic       data_stall, mdu_stall, stall;
    logic [3:0] cnt_q, cnt_d;
    logic       unused;

    instr_class u_cls_d (.ir_i(IR_D), .cls_o(cls_d), .waddr_o(wa_d), .tnew_o(tnew_d));
    instr_class u_cls_e (.ir_i(IR_E), .cls_o(cls_e), .waddr_o(wa_e), .tnew_o(tnew_e));
    instr_class u_cls_m (.ir_i(IR_M), .cls_o(cls_m), .waddr_o(wa_m), .tnew_o(tnew_m));
    instr_class u_cls_w (.ir_i(IR_W), .cls_o(cls_w), .waddr_o(wa_w), .tnew_o(tnew_w));

    assign unused = ^{wa_d, tnew_d, tnew_w, cls_w};

    function automatic logic hit(input logic [4:0] a, input logic [4:0] r);
        return (a != 5'd0) && (a == r);
    endfunction

    // Nearest producer wins; a matching producer with nothing ready selects 0
    // (the stall or a later E-stage forward covers it).
    function automatic logic [2:0] fwd_d(input logic [4:0] r,
                                         input iclass_e ce, input logic [4:0] ae,
                                         input iclass_e cm, input logic [4:0] am,
                                         input logic [4:0] aw);
        if (hit(ae, r))      return (ce == CLS_JAL) ? FWD_D_PC8_E : FWD_D_GRF;
        else if (hit(am, r)) return (cm == CLS_JAL) ? FWD_D_PC8_M :
                                    alu_result(cm)  ? FWD_D_ALU_M : FWD_D_GRF;
        else if (hit(aw, r)) return FWD_D_GRF_WD;
        else                 return FWD_D_GRF;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] r,
                                         input iclass_e cm, input logic [4:0] am,
                                         input logic [4:0] aw);
        if (hit(am, r))      return (cm == CLS_JAL) ? FWD_E_PC8_M :
                                    alu_result(cm)  ? FWD_E_ALU_M : FWD_E_REG;
        else if (hit(aw, r)) return FWD_E_GRF_WD;
        else                 return FWD_E_REG;
    endfunction

    // Tnew counts down by one stage as the producer moves E -> M
    assign tnew_m_eff = (tnew_m != 2'd0) ? tnew_m - 2'd1 : 2'd0;

    assign data_stall =
        (hit(wa_e, IR_D[25:21]) && (tuse_rs(cls_d) < tnew_e))     ||
        (hit(wa_m, IR_D[25:21]) && (tuse_rs(cls_d) < tnew_m_eff)) ||
        (hit(wa_e, IR_D[20:16]) && (tuse_rt(cls_d) < tnew_e))     ||
        (hit(wa_m, IR_D[20:16]) && (tuse_rt(cls_d) < tnew_m_eff));

    assign mdu_stall = is_mdu(cls_d) && md_busy;
    assign stall     = data_stall || mdu_stall;
    assign PCNen     = stall;
    assign FD_Nen    = stall;
    assign DE_clr    = stall;

    assign Forward_RSD = fwd_d(IR_D[25:21], cls_e, wa_e, cls_m, wa_m, wa_w);
    assign Forward_RTD = fwd_d(IR_D[20:16], cls_e, wa_e, cls_m, wa_m, wa_w);
    assign Forward_RSE = fwd_e(IR_E[25:21], cls_m, wa_m, wa_w);
    assign Forward_RTE = fwd_e(IR_E[20:16], cls_m, wa_m, wa_w);
    assign Forward_RTM = (cls_m == CLS_STORE) && hit(wa_w, IR_M[20:16]);

    // MDU busy tracker: a start is only taken when idle, so a stray MDU op
    // in E during a count never reloads the counter.
    always_comb begin
        md_start_E = 1'b0;
        cnt_d      = cnt_q;
        if (cnt_q == 4'd0 && cls_e == CLS_MULT) begin
            md_start_E = 1'b1;
            cnt_d      = 4'(MULT_CYCLES);
        end else if (cnt_q == 4'd0 && cls_e == CLS_DIV) begin
            md_start_E = 1'b1;
            cnt_d      = 4'(DIV_CYCLES);
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= 4'd0;
        else       cnt_q <= cnt_d;
    end

    assign md_busy = (cnt_q != 4'd0) || md_start_E;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, md_stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q    <= 32'd0;
            md_stall_cnt_q <= 32'd0;
        end else begin
            if (stall)     stall_cnt_q    <= stall_cnt_q + 32'd1;
            if (mdu_stall) md_stall_cnt_q <= md_stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign md_stall_cnt = md_stall_cnt_q;
`else
    // Counters not built; stall behaviour is unaffected.
`endif

endmodule
